// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side engines.
//   entry_meta_t  : per-entry control flags carried next to the data word
//   rd_state_e    : packet-tracking state of the read-side drain engine
//   fifo_last_bit : index of the last flag inside a FIFO entry of a given
//                   data width (the flag sits directly above the data bits)
package fifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } rd_state_e;

    // A buffered stream entry is {data, entry_meta_t}; the data width is a
    // per-instance parameter, so only the flags are fixed here.
    typedef struct packed {
        logic last;
        logic trunc;
    } entry_meta_t;

    function automatic int fifo_last_bit(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry output stage: a main register that drives the stream pins and a
// skid register behind it, so the upstream load handshake never has to look
// at m_ready combinationally.
//   clk, rst_n            : clock, async active-low reset
//   ld_valid/ld_data/ld_meta : entry loaded this cycle
//   skid_valid            : skid occupied (upstream must not load a third)
//   m_data/m_meta/m_valid/m_ready : registered stream output
module axis_skid_buffer
    import fifo_pkg::*;
#(
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    input  logic [W-1:0] ld_data,
    input  entry_meta_t ld_meta,
    output logic        skid_valid,
    output logic [W-1:0] m_data,
    output entry_meta_t m_meta,
    output logic        m_valid,
    input  logic        m_ready
);

    logic [W-1:0] skid_data;
    entry_meta_t  skid_meta;
    logic         main_free;

    // Main can take a new entry when empty or when its current one leaves.
    assign main_free = !m_valid || m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data     <= '0;
            m_meta     <= '0;
            m_valid    <= 1'b0;
            skid_data  <= '0;
            skid_meta  <= '0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                // Older skid entry goes first; a concurrent load backfills skid.
                m_data  <= skid_data;
                m_meta  <= skid_meta;
                m_valid <= 1'b1;
                if (ld_valid) begin
                    skid_data <= ld_data;
                    skid_meta <= ld_meta;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (ld_valid) begin
                m_data  <= ld_data;
                m_meta  <= ld_meta;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (ld_valid) begin
            skid_data  <= ld_data;
            skid_meta  <= ld_meta;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a first-word-fall-through FIFO onto an AXI-Stream master port.
// Splits packets longer than MAX_PKT_LEN beats (forced last + trunc flag)
// and reports the length of every completed output packet.
//   clk, rst_n        : clock, async active-low reset
//   fifo_empty_i      : FIFO empty
//   fifo_data_i       : FIFO head {last, data}
//   fifo_pop_o        : consume FIFO head this cycle
//   m_data_o/m_last_o/m_valid_o/m_ready_i : stream master
//   busy_o            : a packet has started on the output but not finished
//   pkt_done_o        : pulse after a last beat is accepted
//   pkt_len_o         : beat count of the latest completed packet
//   trunc_o           : pulse after a forced-last beat is accepted
module fifo_axis_reader
    import fifo_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int MAX_PKT_LEN  = 256,
    parameter int LEN_W        = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fifo_empty_i,
    input  logic [T_DATA_WIDTH:0]   fifo_data_i,
    output logic                    fifo_pop_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    busy_o,
    output logic                    pkt_done_o,
    output logic [LEN_W-1:0]        pkt_len_o,
    output logic                    trunc_o
);

    localparam int LAST_BIT = fifo_last_bit(T_DATA_WIDTH);

    logic        skid_valid;
    logic        in_last;
    logic        force_last;
    logic        acc;
    entry_meta_t ld_meta;
    entry_meta_t m_meta;
    logic [LEN_W-1:0] ld_cnt;
    logic [LEN_W-1:0] out_cnt;
    rd_state_e   state, state_nxt;

    // Pop only depends on local buffer occupancy, never on m_ready_i.
    assign fifo_pop_o = !fifo_empty_i && !skid_valid;

    // Truncation is decided on the load side, so the split is already
    // baked into the buffered entry by the time it reaches the pins.
    assign in_last    = fifo_data_i[LAST_BIT];
    assign force_last = !in_last && (ld_cnt == LEN_W'(MAX_PKT_LEN - 1));
    assign ld_meta    = '{last: in_last || force_last, trunc: force_last};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ld_cnt <= '0;
        else if (fifo_pop_o)
            ld_cnt <= ld_meta.last ? '0 : ld_cnt + LEN_W'(1);
    end

    axis_skid_buffer #(
        .W(T_DATA_WIDTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_valid   (fifo_pop_o),
        .ld_data    (fifo_data_i[T_DATA_WIDTH-1:0]),
        .ld_meta    (ld_meta),
        .skid_valid (skid_valid),
        .m_data     (m_data_o),
        .m_meta     (m_meta),
        .m_valid    (m_valid_o),
        .m_ready    (m_ready_i)
    );

    assign m_last_o = m_meta.last;
    assign acc      = m_valid_o && m_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_o    = (state == BUSY);
        if (acc)
            state_nxt = m_meta.last ? IDLE : BUSY;
    end

    // Output-side accounting; everything here only moves on a handshake,
    // so an underrun mid-packet simply freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt    <= '0;
            pkt_len_o  <= '0;
            pkt_done_o <= 1'b0;
            trunc_o    <= 1'b0;
        end else begin
            pkt_done_o <= acc && m_meta.last;
            trunc_o    <= acc && m_meta.last && m_meta.trunc;
            if (acc) begin
                if (m_meta.last) begin
                    pkt_len_o <= out_cnt + LEN_W'(1);
                    out_cnt   <= '0;
                end else begin
                    out_cnt <= out_cnt + LEN_W'(1);
                end
            end
        end
    end

endmodule
